// File: rtl/vec_mem_pkg.sv
// Shared constants, FSM state type and sizing helper for the vector memory stage.
package vec_mem_pkg;

  localparam int unsigned MEM_EN_BIT = 3;
  localparam logic [2:0]  OP_LOAD    = 3'b000;
  localparam logic [2:0]  OP_STORE   = 3'b001;

  typedef enum logic [1:0] {IDLE, READ, DRAIN, WRITE} state_e;

  function automatic int unsigned calc_beats(input int unsigned lanes,
                                             input int unsigned beat_lanes);
    return lanes / beat_lanes;
  endfunction

endpackage

// File: rtl/vector_data_mem.sv
// Single-port data RAM with per-element write enables and a registered read port.
module vector_data_mem #(
  parameter int unsigned DEPTH  = 4096,
  parameter int unsigned LANES  = 8,
  parameter int unsigned ELEM_W = 8,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned WORD_W = LANES * ELEM_W
) (
  input  logic              clk,
  input  logic              re,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [LANES-1:0]  be,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [LANES-1:0][ELEM_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < int'(LANES); i++) begin
        if (be[i]) begin
          mem[addr][i] <= wdata[i*ELEM_W +: ELEM_W];
        end
      end
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/vec_mem_stage.sv
// Vector memory stage: beat-sequenced loads and masked stores against a narrow
// local RAM, single-cycle pass-through for non-memory instructions.
module vec_mem_stage
  import vec_mem_pkg::*;
#(
  parameter int unsigned LANES      = 24,
  parameter int unsigned ELEM_W     = 8,
  parameter int unsigned BEAT_LANES = 8,
  parameter int unsigned ADDR_W     = 21,
  parameter int unsigned MEM_DEPTH  = 4096,
  localparam int unsigned VEC_W     = LANES * ELEM_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        mem_ctrl,
  input  logic [ADDR_W-1:0] dir_mem,
  input  logic [VEC_W-1:0]  data_in,
  input  logic [LANES-1:0]  lane_mask,
  output logic              out_valid,
  output logic [VEC_W-1:0]  data_out,
  output logic              err
);

  localparam int unsigned BEATS  = calc_beats(LANES, BEAT_LANES);
  localparam int unsigned WORD_W = BEAT_LANES * ELEM_W;
  localparam int unsigned MEM_AW = $clog2(MEM_DEPTH);
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned CHK_W  = ADDR_W + 1;

  state_e state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic              out_valid_q, out_valid_d;
  logic              err_q, err_d;
  logic [VEC_W-1:0]  data_out_q, data_out_d;

  logic [MEM_AW-1:0]                      addr_q;
  logic [BEATS-1:0][WORD_W-1:0]           data_q;
  logic [BEATS-1:0][BEAT_LANES-1:0]       mask_q;
  logic [BEATS-1:0][WORD_W-1:0]           load_buf_q, load_next;
  logic                                   ren_q;
  logic [BEAT_W-1:0]                      ridx_q;

  logic              accept;
  logic              last_beat;
  logic [CHK_W-1:0]  end_addr;
  logic              range_bad, op_bad;
  logic              mem_re, mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [WORD_W-1:0] mem_rdata;

  assign in_ready  = (state_q == IDLE) && !rst;
  assign accept    = in_valid && in_ready;
  assign last_beat = (beat_q == BEAT_W'(BEATS - 1));

  // Widened by one bit so a base near the top of the address space cannot wrap.
  assign end_addr  = {1'b0, dir_mem} + CHK_W'(BEATS - 1);
  assign range_bad = end_addr >= CHK_W'(MEM_DEPTH);
  assign op_bad    = (mem_ctrl[2:0] != OP_LOAD) && (mem_ctrl[2:0] != OP_STORE);

  assign mem_addr  = addr_q + MEM_AW'(beat_q);

  // Word returned by last cycle's read drops into its slice of the vector.
  always_comb begin
    load_next = load_buf_q;
    if (ren_q) begin
      load_next[ridx_q] = mem_rdata;
    end
  end

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    out_valid_d = 1'b0;
    err_d       = 1'b0;
    data_out_d  = data_out_q;
    mem_re      = 1'b0;
    mem_we      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          beat_d = '0;
          if (!mem_ctrl[MEM_EN_BIT]) begin
            out_valid_d = 1'b1;
            data_out_d  = data_in;
          end else if (range_bad || op_bad) begin
            out_valid_d = 1'b1;
            err_d       = 1'b1;
            data_out_d  = '0;
          end else if (mem_ctrl[2:0] == OP_LOAD) begin
            state_d = READ;
          end else begin
            state_d = WRITE;
          end
        end
      end
      READ: begin
        mem_re = 1'b1;
        if (last_beat) begin
          state_d = DRAIN;
          beat_d  = '0;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      DRAIN: begin
        state_d     = IDLE;
        out_valid_d = 1'b1;
        data_out_d  = load_next;
      end
      WRITE: begin
        mem_we = !rst;
        if (last_beat) begin
          state_d     = IDLE;
          beat_d      = '0;
          out_valid_d = 1'b1;
          data_out_d  = '0;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        beat_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
      data_out_q  <= '0;
      ren_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
      data_out_q  <= data_out_d;
      ren_q       <= mem_re;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q <= dir_mem[MEM_AW-1:0];
      data_q <= data_in;
      mask_q <= lane_mask;
    end
    ridx_q     <= beat_q;
    load_buf_q <= load_next;
  end

  vector_data_mem #(
    .DEPTH  (MEM_DEPTH),
    .LANES  (BEAT_LANES),
    .ELEM_W (ELEM_W)
  ) u_mem (
    .clk   (clk),
    .re    (mem_re),
    .we    (mem_we),
    .addr  (mem_addr),
    .be    (mask_q[beat_q]),
    .wdata (data_q[beat_q]),
    .rdata (mem_rdata)
  );

  assign out_valid = out_valid_q;
  assign err       = err_q;
  assign data_out  = data_out_q;

endmodule

// File: tb/tb_vec_mem_stage.sv
// Scoreboard bench for vec_mem_stage against an element-addressed memory model.
module tb_vec_mem_stage;

  localparam int LANES      = 24;
  localparam int ELEM_W     = 8;
  localparam int BEAT_LANES = 8;
  localparam int ADDR_W     = 21;
  localparam int MEM_DEPTH  = 4096;
  localparam int BEATS      = LANES / BEAT_LANES;
  localparam int VEC_W      = LANES * ELEM_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        mem_ctrl;
  logic [ADDR_W-1:0] dir_mem;
  logic [VEC_W-1:0]  data_in;
  logic [LANES-1:0]  lane_mask;
  logic              out_valid;
  logic [VEC_W-1:0]  data_out;
  logic              err;

  vec_mem_stage dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mem_ctrl  (mem_ctrl),
    .dir_mem   (dir_mem),
    .data_in   (data_in),
    .lane_mask (lane_mask),
    .out_valid (out_valid),
    .data_out  (data_out),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [VEC_W-1:0] data;
    logic             err;
    int               cyc;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] mref [MEM_DEPTH*BEAT_LANES];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Element e of the flat model lives at word e/BEAT_LANES, lane e%BEAT_LANES.
  function automatic logic [VEC_W-1:0] ref_load(input int addr);
    logic [VEC_W-1:0] v;
    for (int i = 0; i < LANES; i++) v[i*ELEM_W +: ELEM_W] = mref[addr*BEAT_LANES + i];
    return v;
  endfunction

  task automatic chk_vec(input string name, input logic [VEC_W-1:0] act,
                         input logic [VEC_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic logic [VEC_W-1:0] rand_vec();
    logic [VEC_W-1:0] v;
    for (int i = 0; i < VEC_W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Drives one instruction until accepted; beats_done limits how much of a store
  // the model applies (for aborted stores), expect_out queues the response.
  task automatic send(input logic [3:0] ctrl, input int addr, input logic [VEC_W-1:0] data,
                      input logic [LANES-1:0] mask, input bit expect_out,
                      input int beats_done, output int acc_cyc);
    exp_t e;
    int   n = 0;
    @(negedge clk);
    in_valid  = 1'b1;
    mem_ctrl  = ctrl;
    dir_mem   = ADDR_W'(addr);
    data_in   = data;
    lane_mask = mask;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual=busy required=ready");
      in_valid = 1'b0;
      acc_cyc  = -1;
      return;
    end
    acc_cyc = cyc + 1;
    e.err   = 1'b0;
    e.data  = '0;
    if (!ctrl[3]) begin
      e.data = data;
      e.cyc  = cyc + 1;
    end else if (addr + BEATS - 1 >= MEM_DEPTH || ctrl[2:0] > 3'd1) begin
      e.err = 1'b1;
      e.cyc = cyc + 1;
    end else if (ctrl[2:0] == 3'd0) begin
      e.data = ref_load(addr);
      e.cyc  = cyc + BEATS + 2;
    end else begin
      for (int i = 0; i < beats_done * BEAT_LANES; i++)
        if (mask[i]) mref[addr*BEAT_LANES + i] = data[i*ELEM_W +: ELEM_W];
      e.cyc = cyc + BEATS + 1;
    end
    if (expect_out) sb.push_back(e);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out actual=%h required=none", data_out);
        end else begin
          e = sb.pop_front();
          chk_vec("out_data", data_out, e.data);
          chk_int("out_err", int'(err), int'(e.err));
          chk_int("out_cycle", cyc, e.cyc);
        end
      end else if (sb.size() > 0 && sb[0].cyc < cyc) begin
        e = sb.pop_front();
        checks++;
        errors++;
        $display("FAIL missing_out actual=none required=cycle %0d", e.cyc);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [VEC_W-1:0] v;
    int               a0, a1, k, addr;

    rst = 1'b1; in_valid = 1'b0; mem_ctrl = '0; dir_mem = '0; data_in = '0; lane_mask = '0;
    repeat (2) @(negedge clk);
    chk_int("ready_in_reset", int'(in_ready), 0);
    rst = 1'b0;
    #1;
    chk_int("rst_out_valid", int'(out_valid), 0);
    chk_int("rst_err", int'(err), 0);
    chk_vec("rst_data_out", data_out, '0);
    chk_int("ready_after_reset", int'(in_ready), 1);

    // Back-to-back pass-through.
    v = {24{8'hA5}};
    for (int i = 0; i < 3; i++) send(4'h0, 0, v, '0, 1'b1, BEATS, a0);
    @(negedge clk);
    chk_int("ready_pass", int'(in_ready), 1);

    // Full store of lane index, then reload.
    for (int i = 0; i < LANES; i++) v[i*ELEM_W +: ELEM_W] = 8'(i);
    send(4'b1001, 'h10, v, {LANES{1'b1}}, 1'b1, BEATS, a0);
    @(negedge clk);
    chk_int("busy_store", int'(in_ready), 0);
    send(4'b1000, 'h10, '0, '0, 1'b1, BEATS, a0);

    // Middle-beat masked overwrite.
    send(4'b1001, 'h10, {24{8'hFF}}, 24'h00FF00, 1'b1, BEATS, a0);
    send(4'b1000, 'h10, '0, '0, 1'b1, BEATS, a0);

    // Top-of-memory boundary.
    send(4'b1001, MEM_DEPTH - 3, rand_vec(), {LANES{1'b1}}, 1'b1, BEATS, a0);
    send(4'b1000, MEM_DEPTH - 2, '0, '0, 1'b1, BEATS, a0);
    send(4'b1000, MEM_DEPTH - 3, '0, '0, 1'b1, BEATS, a0);

    // Reserved opcode, next instruction accepted the following edge.
    send(4'b1010, 'h10, rand_vec(), '1, 1'b1, BEATS, a0);
    send(4'h0, 0, rand_vec(), '0, 1'b1, BEATS, a1);
    chk_int("reserved_next_accept", a1, a0 + 1);

    // Store aborted by reset after its first beat.
    send(4'b1001, 'h20, rand_vec(), {LANES{1'b1}}, 1'b1, BEATS, a0);
    send(4'b1001, 'h20, rand_vec(), {LANES{1'b1}}, 1'b0, 1, a0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_int("ready_after_abort", int'(in_ready), 1);
    send(4'b1000, 'h20, '0, '0, 1'b1, BEATS, a0);

    // Randomised mix over a pre-filled region.
    for (int i = 0; i < 6; i++) send(4'b1001, 'h100 + 3*i, rand_vec(), '1, 1'b1, BEATS, a0);
    for (int i = 0; i < 60; i++) begin
      k    = $urandom_range(0, 9);
      addr = 'h100 + $urandom_range(0, 15);
      if (k < 2)       send(4'h0, addr, rand_vec(), '0, 1'b1, BEATS, a0);
      else if (k < 5)  send(4'b1000, addr, '0, '0, 1'b1, BEATS, a0);
      else if (k < 8)  send(4'b1001, addr, rand_vec(), LANES'($urandom), 1'b1, BEATS, a0);
      else if (k == 8) send({1'b1, 3'($urandom_range(2, 7))}, addr, rand_vec(), '1, 1'b1,
                            BEATS, a0);
      else             send(4'b1000, ($urandom_range(0, 1) != 0) ? 'h1FFFFF : MEM_DEPTH - 1,
                            '0, '0, 1'b1, BEATS, a0);
    end

    repeat (10) @(negedge clk);
    chk_int("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
